clock_time_core: RTL and testbench
==================================

# clock_time_core

BCD timekeeping and alarm core for the digital clock: divides CP1 into a one-second tick and maintains hour/minute/second counters. It also holds the alarm set-point, applies user adjust keys, and raises the alarm ring. It sits directly upstream of the display controller, which consumes Hour, Minutes, Second, AHour and AMinutes as packed BCD bytes.

## Interface
- TICK_DIV, 50000000, CP1 cycles per second tick; must be at least 2.
- RING_SEC, 60, ring duration in seconds; range 1..255.
- CP1  in  1  system clock, rising-edge active.
- CR  in  1  reset, asynchronous, active-high.
- AdjMinKey  in  1  debounced level, asynchronous to CP1; a rising edge means "minute +1".
- AdjHourKey  in  1  debounced level, asynchronous to CP1; a rising edge means "hour +1".
- SetAlarm  in  1  when 1, adjust keys target the alarm registers instead of time.
- AlarmEnable  in  1  arms the alarm.
- Hour  out  8  BCD: [7:4] tens, [3:0] units; range 00–23.
- Minutes  out  8  BCD; range 00–59.
- Second  out  8  BCD; range 00–59.
- AHour  out  8  BCD alarm hour.
- AMinutes  out  8  BCD alarm minute.
- SecPulse  out  1  one-cycle strobe on each second tick.
- AlarmRing  out  1  high while the alarm sounds.

## Operation
- Reset (CR=1, asynchronous):
  - Hour=8'h00, Minutes=8'h00, Second=8'h00.
  - AHour=8'h07, AMinutes=8'h00.
  - SecPulse=0, AlarmRing=0.
  - Divider=0, ring counter=0, sync/edge flops=0, FSM=IDLE.
- Divider counts 0..TICK_DIV-1 and wraps. SecPulse=1 for exactly the cycle in which the divider equals TICK_DIV-1.
- Tick (SecPulse=1): Second increments in BCD.
  - Units 9→0 carries into tens; 59→00 carries into Minutes.
  - Minutes 59→00 carries into Hour.
  - Hour 23→00 (wrap). The full rollover is 23:59:59→00:00:00.
- BCD digits are never outside 0–9 and no field exceeds its range. Every field update is a single BCD increment with wrap; there is no binary intermediate.
- Keys: each key passes through a 2-flop synchronizer plus a previous-value flop. edge = sync2 & ~prev.
- Minute key edge, not consumed by ring:
  - SetAlarm=0: Minutes +1 mod 60. No carry into Hour; Second is unchanged.
  - SetAlarm=1: AMinutes +1 mod 60.
- Hour key edge, not consumed by ring:
  - SetAlarm=0: Hour +1 mod 24.
  - SetAlarm=1: AHour +1 mod 24.
- Both key edges in the same cycle: both increments apply.
- Tick and time-adjust in the same cycle:
  - Second still advances.
  - The adjusted field takes key+1. Any tick carry into that field is dropped.
  - The carry chain beyond the adjusted field is not triggered by the key.
- Alarm FSM:
  - IDLE→RINGING when AlarmEnable=1 and a tick produces Hour==AHour, Minutes==AMinutes, Second==8'h00. The comparison uses the post-tick values.
  - RINGING: AlarmRing=1; the ring counter increments on each SecPulse.
  - RINGING→IDLE on any one of these, with AlarmRing=0 the next cycle:
    - the ring counter reaches RING_SEC;
    - AlarmEnable=0;
    - any key edge.
  - A key edge that silences the ring is consumed: no adjust is applied.
  - Ring counter clears on entry to RINGING.
- A match is detected only on a tick. Setting the alarm to the current time does not ring until the next exact match.

## Timing
- SecPulse is asserted combinationally-free (registered) in the divider's terminal cycle. Time outputs update at the rising edge that ends that cycle.
- Tick period is exactly TICK_DIV CP1 cycles; the first SecPulse comes TICK_DIV cycles after CR deasserts.
- Key latency: a register changes on the 3rd CP1 rising edge after the key is first sampled high. A held key yields exactly one increment.
- AlarmRing rises on the same edge that Second becomes 00 at the match. It falls on the edge where Second shows 00+RING_SEC (mod 60) seconds later.
- CR asserted mid-ring or mid-adjust clears everything immediately. There is no pending action after release.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- TICK_DIV=4, reset, run 16 cycles:
  - SecPulse fires at cycles 4, 8, 12, 16.
  - Second goes 01, 02, 03, 04; reset values are checked before the first pulse.
- Preload to 23:59:58 via keys, tick twice: 23:59:59, then 00:00:00.
- SetAlarm=0, pulse AdjMinKey 61 times from 00: Minutes ends at 8'h01, Hour stays 8'h00.
- Same-cycle check: at 00:59:59, align an AdjMinKey edge with the tick. Result is 00:00:00 with Hour unchanged; the carry is dropped.
- SetAlarm=1:
  - 2 minute edges and 1 hour edge give AHour=8'h08, AMinutes=8'h02.
  - Time at 08:01:59 with AlarmEnable=1: the tick raises AlarmRing.
  - With RING_SEC=3, AlarmRing falls after 3 more ticks at 08:02:03.
- During RINGING, an AdjHourKey edge drops AlarmRing and leaves Hour unchanged. Repeat with AlarmEnable=0 mid-ring; AlarmRing drops the next cycle.

Source files
------------

// File: rtl/clock_time_core.sv
// clock_time_core: BCD time-of-day counter with one-second divider, adjust keys and alarm ring
// Ports:
//   CP1 clock (rising edge), CR asynchronous active-high reset
//   AdjMinKey / AdjHourKey  asynchronous key levels, each rising edge means +1
//   SetAlarm     steers the adjust keys to the alarm registers
//   AlarmEnable  arms the alarm
//   Hour / Minutes / Second / AHour / AMinutes  packed BCD bytes
//   SecPulse     one-cycle strobe on each second tick
//   AlarmRing    high while the alarm sounds
module clock_time_core #(
    parameter int TICK_DIV = 50000000,
    parameter int RING_SEC = 60
) (
    input  logic       CP1,
    input  logic       CR,
    input  logic       AdjMinKey,
    input  logic       AdjHourKey,
    input  logic       SetAlarm,
    input  logic       AlarmEnable,
    output logic [7:0] Hour,
    output logic [7:0] Minutes,
    output logic [7:0] Second,
    output logic [7:0] AHour,
    output logic [7:0] AMinutes,
    output logic       SecPulse,
    output logic       AlarmRing
);
    localparam int            DW       = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(TICK_DIV - 2);
    localparam logic [7:0]    RING_END = 8'(RING_SEC);
    localparam logic [0:0]    IDLE     = 1'b0;
    localparam logic [0:0]    RINGING  = 1'b1;

    logic [DW-1:0] div;
    logic [1:0]    min_sync, hr_sync;
    logic          min_prev, hr_prev;
    logic [0:0]    state, state_n;
    logic [7:0]    ring_cnt, ring_n;
    logic [7:0]    hr_n, min_n, sec_n, ahr_n, amin_n;
    logic          min_edge, hr_edge, min_go, hr_go;
    logic          t_min, t_hr, a_min, a_hr;
    logic          sec_wrap, min_wrap, ringing, hit, stop;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        return (v == top) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
    endfunction

    assign AlarmRing = (state == RINGING);

    always_comb begin
        ringing  = (state == RINGING);
        min_edge = min_sync[1] & ~min_prev;
        hr_edge  = hr_sync[1] & ~hr_prev;
        // a key edge that silences the ring is swallowed
        min_go   = min_edge & ~ringing;
        hr_go    = hr_edge & ~ringing;
        t_min    = min_go & ~SetAlarm;
        t_hr     = hr_go & ~SetAlarm;
        a_min    = min_go & SetAlarm;
        a_hr     = hr_go & SetAlarm;
        sec_wrap = SecPulse & (Second == 8'h59);
        // a same-cycle minute adjust absorbs the tick carry, so nothing ripples into Hour
        min_wrap = sec_wrap & ~t_min & (Minutes == 8'h59);
        sec_n    = SecPulse ? bcd_inc(Second, 8'h59) : Second;
        min_n    = (t_min | sec_wrap) ? bcd_inc(Minutes, 8'h59) : Minutes;
        hr_n     = (t_hr | min_wrap) ? bcd_inc(Hour, 8'h23) : Hour;
        amin_n   = a_min ? bcd_inc(AMinutes, 8'h59) : AMinutes;
        ahr_n    = a_hr ? bcd_inc(AHour, 8'h23) : AHour;
        hit      = SecPulse & AlarmEnable & (sec_n == 8'h00) & (min_n == amin_n) & (hr_n == ahr_n);
        stop     = (SecPulse & (ring_cnt + 8'd1 >= RING_END)) | ~AlarmEnable | min_edge | hr_edge;
        state_n  = ringing ? (stop ? IDLE : RINGING) : (hit ? RINGING : IDLE);
        ring_n   = (ringing && state_n == RINGING) ? ring_cnt + {7'd0, SecPulse} : 8'h00;
    end

    always_ff @(posedge CP1 or posedge CR) begin
        if (CR) begin
            div      <= '0;
            SecPulse <= 1'b0;
            Hour     <= 8'h00;
            Minutes  <= 8'h00;
            Second   <= 8'h00;
            AHour    <= 8'h07;
            AMinutes <= 8'h00;
            state    <= IDLE;
            ring_cnt <= 8'h00;
            min_sync <= 2'b00;
            hr_sync  <= 2'b00;
            min_prev <= 1'b0;
            hr_prev  <= 1'b0;
        end else begin
            div      <= (div == DIV_LAST) ? '0 : div + 1'b1;
            // registered so the strobe lines up with the divider's terminal count
            SecPulse <= (div == DIV_PRE);
            Hour     <= hr_n;
            Minutes  <= min_n;
            Second   <= sec_n;
            AHour    <= ahr_n;
            AMinutes <= amin_n;
            state    <= state_n;
            ring_cnt <= ring_n;
            min_sync <= {min_sync[0], AdjMinKey};
            hr_sync  <= {hr_sync[0], AdjHourKey};
            min_prev <= min_sync[1];
            hr_prev  <= hr_sync[1];
        end
    end
endmodule

// File: tb/tb_clock_time_core.sv
// tb_clock_time_core: directed and randomized checks of clock_time_core against a seconds-of-day model
module tb_clock_time_core;
    localparam int TD = 4;
    localparam int RS = 3;
    localparam logic [41:0] RST_V = {8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 2'b00};

    logic CP1 = 1'b0;
    logic CR = 1'b1;
    logic AdjMinKey = 1'b0;
    logic AdjHourKey = 1'b0;
    logic SetAlarm = 1'b0;
    logic AlarmEnable = 1'b0;
    logic [7:0] Hour, Minutes, Second, AHour, AMinutes;
    logic SecPulse, AlarmRing;
    logic [41:0] dut_v, exp_v;

    int n_chk = 0;
    int n_fail = 0;

    // model: time as seconds of day, alarm as minutes of day
    int m_t = 0;
    int m_a = 420;
    int m_rc = 0;
    int m_cnt = 0;
    bit m_ring = 1'b0;
    bit [2:0] hm = 3'b000;
    bit [2:0] hh = 3'b000;

    clock_time_core #(.TICK_DIV(TD), .RING_SEC(RS)) dut (
        .CP1(CP1), .CR(CR), .AdjMinKey(AdjMinKey), .AdjHourKey(AdjHourKey),
        .SetAlarm(SetAlarm), .AlarmEnable(AlarmEnable), .Hour(Hour), .Minutes(Minutes),
        .Second(Second), .AHour(AHour), .AMinutes(AMinutes), .SecPulse(SecPulse),
        .AlarmRing(AlarmRing)
    );

    always #5 CP1 = ~CP1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    assign dut_v = {Hour, Minutes, Second, AHour, AMinutes, SecPulse, AlarmRing};
    always_comb exp_v = {bcd(m_t / 3600), bcd((m_t / 60) % 60), bcd(m_t % 60),
                         bcd(m_a / 60), bcd(m_a % 60), 1'(((m_cnt + 1) % TD) == 0), m_ring};

    always @(posedge CP1 or posedge CR) begin : mdl
        int s, mi, h, am, ah, nc, rc;
        bit tk, em, eh, km, kh, cs, cm, rg;
        if (CR) begin
            m_t <= 0; m_a <= 420; m_rc <= 0; m_cnt <= 0; m_ring <= 1'b0;
            hm <= 3'b000; hh <= 3'b000;
        end else begin
            nc = m_cnt + 1;
            tk = (nc % TD) == 0;
            em = hm[1] & ~hm[2];
            eh = hh[1] & ~hh[2];
            km = em & ~m_ring;
            kh = eh & ~m_ring;
            s = m_t % 60; mi = (m_t / 60) % 60; h = m_t / 3600;
            am = m_a % 60; ah = m_a / 60;
            cs = tk && s == 59;
            cm = cs && mi == 59 && !(km && !SetAlarm);
            if (tk) s = (s + 1) % 60;
            if ((km && !SetAlarm) || cs) mi = (mi + 1) % 60;
            if ((kh && !SetAlarm) || cm) h = (h + 1) % 24;
            if (km && SetAlarm) am = (am + 1) % 60;
            if (kh && SetAlarm) ah = (ah + 1) % 24;
            rg = m_ring; rc = m_rc;
            if (m_ring) begin
                if (tk) rc = rc + 1;
                if (rc >= RS || !AlarmEnable || em || eh) begin rg = 1'b0; rc = 0; end
            end else if (tk && AlarmEnable && s == 0 && mi == am && h == ah) begin
                rg = 1'b1; rc = 0;
            end
            m_t <= h * 3600 + mi * 60 + s;
            m_a <= ah * 60 + am;
            m_rc <= rc;
            m_cnt <= nc;
            m_ring <= rg;
            hm <= {hm[1:0], AdjMinKey};
            hh <= {hh[1:0], AdjHourKey};
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CP1);
    endtask

    task automatic press(input bit m, input bit h, input int n);
        repeat (n) begin
            @(negedge CP1); AdjMinKey = m; AdjHourKey = h;
            @(negedge CP1); AdjMinKey = 1'b0; AdjHourKey = 1'b0;
        end
    endtask

    task automatic do_reset;
        @(negedge CP1); CR = 1'b1;
        cyc(2);
        CR = 1'b0;
    endtask

    task automatic wait_sec(input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge CP1);
            ok = (m_t % 60) == v;
        end
    endtask

    task automatic wait_pulse(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * TD && !ok; i++) begin
            @(negedge CP1);
            ok = (SecPulse === 1'b1);
        end
        @(negedge CP1);
    endtask

    task automatic setup_ring(output bit ok);
        do_reset();
        AlarmEnable = 1'b1;
        SetAlarm = 1'b1;
        press(1'b1, 1'b1, 1);
        press(1'b0, 1'b1, 16);
        cyc(3);
        SetAlarm = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge CP1);
            ok = (AlarmRing === 1'b1);
        end
    endtask

    task automatic test_reset;
        CR = 1'b1;
        cyc(3);
        n_chk++;
        if (dut_v !== RST_V) begin
            n_fail++; $display("FAIL reset: got %h expected %h", dut_v, RST_V);
        end
    endtask

    task automatic test_divider;
        @(negedge CP1); CR = 1'b0;
        #1;
        for (int k = 1; k <= 17; k++) begin
            if (k > 1) @(negedge CP1);
            n_chk++;
            if (SecPulse !== 1'(k % TD == 0)) begin
                n_fail++; $display("FAIL divider_pulse cycle %0d: got %b expected %b", k, SecPulse, k % TD == 0);
            end
            n_chk++;
            if (Second !== bcd((k - 1) / TD)) begin
                n_fail++; $display("FAIL divider_second cycle %0d: got %h expected %h", k, Second, bcd((k - 1) / TD));
            end
        end
        n_chk++;
        if (dut_v !== exp_v) begin
            n_fail++; $display("FAIL divider_model: got %h expected %h", dut_v, exp_v);
        end
    endtask

    task automatic test_preload;
        bit ok;
        int nh, nm;
        wait_sec(1, ok);
        nh = (23 - m_t / 3600 + 24) % 24;
        nm = (59 - (m_t / 60) % 60 + 60) % 60;
        for (int i = 0; i < nh || i < nm; i++) press(i < nm, i < nh, 1);
        cyc(3);
        wait_sec(58, ok);
        n_chk++;
        if (!ok || {Hour, Minutes, Second} !== 24'h235958) begin
            n_fail++; $display("FAIL preload: got %h expected 235958", {Hour, Minutes, Second});
        end
        wait_pulse(ok);
        n_chk++;
        if (!ok || {Hour, Minutes, Second} !== 24'h235959) begin
            n_fail++; $display("FAIL tick_235959: got %h expected 235959", {Hour, Minutes, Second});
        end
        wait_pulse(ok);
        n_chk++;
        if (!ok || {Hour, Minutes, Second} !== 24'h000000) begin
            n_fail++; $display("FAIL rollover: got %h expected 000000", {Hour, Minutes, Second});
        end
    endtask

    task automatic test_min_wrap;
        press(1'b1, 1'b0, 61);
        cyc(3);
        n_chk++;
        if ({Hour, Minutes} !== 16'h0001) begin
            n_fail++; $display("FAIL min_wrap: got %h expected 0001", {Hour, Minutes});
        end
        n_chk++;
        if (dut_v !== exp_v) begin
            n_fail++; $display("FAIL min_wrap_model: got %h expected %h", dut_v, exp_v);
        end
    endtask

    task automatic test_same_cycle;
        bit ok;
        do_reset();
        press(1'b1, 1'b0, 59);
        cyc(3);
        wait_sec(59, ok);
        n_chk++;
        if (!ok || {Hour, Minutes, Second} !== 24'h005959) begin
            n_fail++; $display("FAIL same_cycle_setup: got %h expected 005959", {Hour, Minutes, Second});
        end
        for (int i = 0; i < 2 * TD && ((m_cnt + 3) % TD) != 0; i++) @(negedge CP1);
        AdjMinKey = 1'b1;
        @(negedge CP1); AdjMinKey = 1'b0;
        cyc(2);
        n_chk++;
        if ({Hour, Minutes, Second} !== 24'h000000) begin
            n_fail++; $display("FAIL same_cycle: got %h expected 000000", {Hour, Minutes, Second});
        end
        cyc(TD);
        n_chk++;
        if (dut_v !== exp_v) begin
            n_fail++; $display("FAIL same_cycle_model: got %h expected %h", dut_v, exp_v);
        end
    endtask

    task automatic test_alarm;
        bit ok;
        do_reset();
        SetAlarm = 1'b1;
        press(1'b1, 1'b1, 1);
        press(1'b1, 1'b0, 1);
        cyc(3);
        SetAlarm = 1'b0;
        n_chk++;
        if ({AHour, AMinutes} !== 16'h0802) begin
            n_fail++; $display("FAIL alarm_set: got %h expected 0802", {AHour, AMinutes});
        end
        AlarmEnable = 1'b1;
        press(1'b1, 1'b1, 1);
        press(1'b0, 1'b1, 7);
        cyc(3);
        wait_sec(59, ok);
        n_chk++;
        if (!ok || {Hour, Minutes, Second, AlarmRing} !== {24'h080159, 1'b0}) begin
            n_fail++; $display("FAIL alarm_pre: got %h/%b expected 080159/0", {Hour, Minutes, Second}, AlarmRing);
        end
        wait_pulse(ok);
        n_chk++;
        if (!ok || {Hour, Minutes, Second, AlarmRing} !== {24'h080200, 1'b1}) begin
            n_fail++; $display("FAIL alarm_ring: got %h/%b expected 080200/1", {Hour, Minutes, Second}, AlarmRing);
        end
        for (int j = 1; j <= RS; j++) begin
            wait_pulse(ok);
            n_chk++;
            if (!ok || Second !== bcd(j) || AlarmRing !== 1'(j < RS)) begin
                n_fail++; $display("FAIL ring_len %0d: got %h/%b expected %h/%b", j, Second, AlarmRing, bcd(j), j < RS);
            end
        end
    endtask

    task automatic test_ring_key;
        bit ok;
        setup_ring(ok);
        n_chk++;
        if (!ok || {Hour, Minutes, Second} !== 24'h000100) begin
            n_fail++; $display("FAIL ring_key_start: got %b %h expected 1 000100", AlarmRing, {Hour, Minutes, Second});
        end
        AdjHourKey = 1'b1;
        @(negedge CP1); AdjHourKey = 1'b0;
        @(negedge CP1);
        n_chk++;
        if (AlarmRing !== 1'b1) begin
            n_fail++; $display("FAIL ring_key_early: got %b expected 1", AlarmRing);
        end
        @(negedge CP1);
        n_chk++;
        if ({AlarmRing, Hour, Minutes} !== {1'b0, 16'h0001}) begin
            n_fail++; $display("FAIL ring_key_stop: got %b %h expected 0 0001", AlarmRing, {Hour, Minutes});
        end
    endtask

    task automatic test_ring_disable;
        bit ok;
        setup_ring(ok);
        n_chk++;
        if (!ok) begin
            n_fail++; $display("FAIL ring_dis_start: got %b expected 1", AlarmRing);
        end
        AlarmEnable = 1'b0;
        @(negedge CP1);
        n_chk++;
        if (AlarmRing !== 1'b0) begin
            n_fail++; $display("FAIL ring_disable: got %b expected 0", AlarmRing);
        end
        AlarmEnable = 1'b1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        setup_ring(ok);
        AdjMinKey = 1'b1;
        @(negedge CP1); CR = 1'b1;
        #1;
        n_chk++;
        if (dut_v !== RST_V) begin
            n_fail++; $display("FAIL reset_mid: got %h expected %h", dut_v, RST_V);
        end
        AdjMinKey = 1'b0;
        @(negedge CP1); CR = 1'b0;
        cyc(6);
        n_chk++;
        if ({Hour, Minutes, AHour, AMinutes, AlarmRing} !== {32'h00000700, 1'b0}) begin
            n_fail++; $display("FAIL reset_pending: got %h %b expected 00000700 0", {Hour, Minutes, AHour, AMinutes}, AlarmRing);
        end
    endtask

    task automatic test_random;
        do_reset();
        AlarmEnable = 1'b1;
        SetAlarm = 1'b1;
        press(1'b1, 1'b1, 1);
        press(1'b0, 1'b1, 16);
        cyc(3);
        SetAlarm = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge CP1);
            n_chk++;
            if (dut_v !== exp_v) begin
                n_fail++; $display("FAIL random cycle %0d: got %h expected %h", i, dut_v, exp_v);
            end
            if ($urandom_range(0, 47) == 0) AdjMinKey = ~AdjMinKey;
            if ($urandom_range(0, 63) == 0) AdjHourKey = ~AdjHourKey;
            if ($urandom_range(0, 199) == 0) SetAlarm = ~SetAlarm;
            if ($urandom_range(0, 299) == 0) AlarmEnable = ~AlarmEnable;
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_preload();
        test_min_wrap();
        test_same_cycle();
        test_alarm();
        test_ring_key();
        test_ring_disable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
